// File: rtl/inst_cache_assoc.sv
// Set-associative instruction cache with tree-PLRU replacement, a valid/ready
// line-fill port, whole-cache flush and saturating hit/miss counters.
module inst_cache_assoc #(
  parameter int INST_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 17,
  parameter int BLOCK_WIDTH = 2,
  parameter int INDEX_WIDTH = 6,
  parameter int WAYS        = 2,
  parameter int CNT_WIDTH   = 32,
  parameter int LINE_WIDTH  = INST_WIDTH << BLOCK_WIDTH,
  parameter int TAG_WIDTH   = ADDR_WIDTH - INDEX_WIDTH - BLOCK_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  fetch_valid,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic                  fetch_done,
  output logic [INST_WIDTH-1:0] fetch_data,
  input  logic                  flush,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ready,
  input  logic                  mem_valid,
  input  logic [LINE_WIDTH-1:0] mem_data,
  output logic [CNT_WIDTH-1:0]  hit_count,
  output logic [CNT_WIDTH-1:0]  miss_count
);

  localparam int SETS   = 1 << INDEX_WIDTH;
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int PLRU_W = (WAYS > 1) ? WAYS - 1 : 1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

  state_t state, state_next;

  logic [TAG_WIDTH-1:0]  tag_mem  [SETS][WAYS];
  logic [LINE_WIDTH-1:0] data_mem [SETS][WAYS];
  logic [WAYS-1:0]       valid    [SETS];
  logic [PLRU_W-1:0]     plru     [SETS];

  logic [TAG_WIDTH-1:0]   f_tag, fill_tag;
  logic [INDEX_WIDTH-1:0] f_idx, fill_idx;
  logic [BLOCK_WIDTH-1:0] f_off;
  logic [WAYS-1:0]        match;
  logic [WAY_W-1:0]       hit_way, victim;
  logic [LINE_WIDTH-1:0]  hit_line;
  logic                   lookup, hit, miss, accept, fill_write, found;

  // Tree-PLRU: bit 0 picks the half, bits 1/2 pick within the left/right pair.
  function automatic logic [1:0] plru_pick(input logic [2:0] b);
    logic [1:0] v;
    v = 2'd0;
    if (WAYS == 2)      v = {1'b0, b[0]};
    else if (WAYS == 4) v = b[0] ? {1'b1, b[2]} : {1'b0, b[1]};
    return v;
  endfunction

  function automatic logic [2:0] plru_touch(input logic [2:0] b, input logic [1:0] w);
    logic [2:0] n;
    n = b;
    if (WAYS == 2) begin
      n[0] = ~w[0];
    end else if (WAYS == 4) begin
      n[0] = ~w[1];
      if (w[1]) n[2] = ~w[0];
      else      n[1] = ~w[0];
    end
    return n;
  endfunction

  assign f_off    = fetch_addr[BLOCK_WIDTH-1:0];
  assign f_idx    = fetch_addr[BLOCK_WIDTH+INDEX_WIDTH-1:BLOCK_WIDTH];
  assign f_tag    = fetch_addr[ADDR_WIDTH-1:BLOCK_WIDTH+INDEX_WIDTH];
  assign fill_idx = mem_addr[BLOCK_WIDTH+INDEX_WIDTH-1:BLOCK_WIDTH];
  assign fill_tag = mem_addr[ADDR_WIDTH-1:BLOCK_WIDTH+INDEX_WIDTH];

  always_comb begin
    match = '0;
    for (int unsigned w = 0; w < WAYS; w++)
      match[w] = valid[f_idx][w] && (tag_mem[f_idx][w] == f_tag);
  end

  always_comb begin
    hit_way = '0;
    for (int unsigned w = 0; w < WAYS; w++)
      if (match[w]) hit_way = WAY_W'(w);
  end

  // A flush cycle in IDLE suppresses the lookup entirely.
  assign lookup     = (state == IDLE) && fetch_valid && rdy && !flush;
  assign hit        = lookup && (|match);
  assign miss       = lookup && !(|match);
  assign accept     = mem_req && mem_ready;
  assign hit_line   = data_mem[f_idx][hit_way];
  assign fetch_done = hit;
  assign fetch_data = hit_line[f_off*INST_WIDTH +: INST_WIDTH];

  always_comb begin
    victim = WAY_W'(plru_pick(3'(plru[fill_idx])));
    found  = 1'b0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!found && !valid[fill_idx][w]) begin
        victim = WAY_W'(w);
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      state <= IDLE;
    else if (rdy) state <= state_next;
  end

  always_comb begin
    state_next = state;
    fill_write = 1'b0;
    case (state)
      IDLE: if (miss) state_next = REQ;
      REQ: begin
        if (flush)       state_next = DROP;
        else if (accept) state_next = WAIT;
      end
      WAIT: begin
        // A flush coinciding with the fill discards it without needing DROP.
        if (flush) begin
          state_next = mem_valid ? IDLE : DROP;
        end else if (mem_valid) begin
          state_next = IDLE;
          fill_write = 1'b1;
        end
      end
      DROP: if (mem_valid && !mem_req) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned s = 0; s < SETS; s++) begin
        valid[s] <= '0;
        plru[s]  <= '0;
      end
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else if (rdy) begin
      if (flush)
        for (int unsigned s = 0; s < SETS; s++) valid[s] <= '0;
      if (miss) begin
        mem_req  <= 1'b1;
        mem_addr <= {fetch_addr[ADDR_WIDTH-1:BLOCK_WIDTH], {BLOCK_WIDTH{1'b0}}};
        if (miss_count != '1) miss_count <= miss_count + 1'b1;
      end else if (accept) begin
        mem_req <= 1'b0;
      end
      if (hit) begin
        plru[f_idx] <= PLRU_W'(plru_touch(3'(plru[f_idx]), 2'(hit_way)));
        if (hit_count != '1) hit_count <= hit_count + 1'b1;
      end
      if (fill_write) begin
        valid[fill_idx][victim] <= 1'b1;
        plru[fill_idx]          <= PLRU_W'(plru_touch(3'(plru[fill_idx]), 2'(victim)));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rdy && fill_write) begin
      tag_mem[fill_idx][victim]  <= fill_tag;
      data_mem[fill_idx][victim] <= mem_data;
    end
  end

  assert property (@(posedge clk) disable iff (rst) (state == IDLE) |-> $onehot0(match));

endmodule
